// File: rtl/cvo_sync_decoder_if.sv
// Bus between the frame counter / config master and the sync decoder.
interface cvo_sync_decoder_if;
    logic        sclr;
    logic        enable;
    logic        start_of_sample;
    logic        new_line;
    logic [13:0] h_count;
    logic [12:0] v_count;
    logic        cfg_load;
    logic [13:0] cfg_h_sync_start, cfg_h_sync_end, cfg_h_act_start, cfg_h_act_end;
    logic [12:0] cfg_v_sync_start, cfg_v_sync_end, cfg_v_act_start, cfg_v_act_end;
    logic        cfg_ack;
    logic        running;
    logic        h_sync, v_sync, h_blank, v_blank, de, sof, eol;

    modport master (
        output sclr, enable, start_of_sample, new_line, h_count, v_count, cfg_load,
               cfg_h_sync_start, cfg_h_sync_end, cfg_h_act_start, cfg_h_act_end,
               cfg_v_sync_start, cfg_v_sync_end, cfg_v_act_start, cfg_v_act_end,
        input  cfg_ack, running, h_sync, v_sync, h_blank, v_blank, de, sof, eol
    );

    modport slave (
        input  sclr, enable, start_of_sample, new_line, h_count, v_count, cfg_load,
               cfg_h_sync_start, cfg_h_sync_end, cfg_h_act_start, cfg_h_act_end,
               cfg_v_sync_start, cfg_v_sync_end, cfg_v_act_start, cfg_v_act_end,
        output cfg_ack, running, h_sync, v_sync, h_blank, v_blank, de, sof, eol
    );
endinterface

// File: rtl/cvo_sync_decoder.sv
// Decodes frame-counter h/v counts into registered sync/blank/de strobes plus
// sof/eol pulses. Timing is double-buffered: cfg_load fills a pending set which
// only becomes active at the next frame start.
module cvo_sync_decoder #(
    parameter bit H_SYNC_POLARITY = 1'b1,
    parameter bit V_SYNC_POLARITY = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    cvo_sync_decoder_if.slave   bus
);
    typedef struct packed {
        logic [13:0] hs_start, hs_end, ha_start, ha_end;
        logic [12:0] vs_start, vs_end, va_start, va_end;
    } timing_t;

    typedef enum logic {IDLE, RUN} state_t;

    // Window membership; start>end wraps through zero, start==end is empty.
    function automatic logic in_win(input logic [13:0] s, input logic [13:0] e,
                                    input logic [13:0] c);
        logic r;
        if (s < e)      r = (c >= s) && (c < e);
        else if (s > e) r = (c >= s) || (c < e);
        else            r = 1'b0;
        return r;
    endfunction

    state_t  state_q, state_d;
    timing_t pend_q, pend_d, act_q, act_d, eff;
    logic    pend_vld_q, pend_vld_d;
    logic    ack_q, ack_d;
    logic    hs_q, hs_d, vs_q, vs_d, hb_q, hb_d, vb_q, vb_d;
    logic    de_q, de_d, sof_q, sof_d, eol_q, eol_d;
    logic    frame_start, apply, decode;
    logic    hs_in, vs_in, ha_in, va_in;

    // Next-state: config double-buffering, FSM and strobe decode.
    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        act_d      = act_q;
        ack_d      = 1'b0;
        hs_d       = hs_q;
        vs_d       = vs_q;
        hb_d       = hb_q;
        vb_d       = vb_q;
        de_d       = de_q;
        sof_d      = 1'b0;
        eol_d      = 1'b0;

        frame_start = bus.enable && bus.start_of_sample &&
                      (bus.h_count == 14'd0) && (bus.v_count == 13'd0);
        apply       = frame_start && pend_vld_q;
        // The apply cycle already decodes with the incoming timing.
        eff         = apply ? pend_q : act_q;
        decode      = ((state_q == RUN) || apply) && bus.enable;

        hs_in = in_win(eff.hs_start, eff.hs_end, bus.h_count);
        ha_in = in_win(eff.ha_start, eff.ha_end, bus.h_count);
        vs_in = in_win({1'b0, eff.vs_start}, {1'b0, eff.vs_end}, {1'b0, bus.v_count});
        va_in = in_win({1'b0, eff.va_start}, {1'b0, eff.va_end}, {1'b0, bus.v_count});

        if (apply) begin
            act_d   = pend_q;
            ack_d   = 1'b1;
            state_d = RUN;
        end
        pend_vld_d = pend_vld_q && !apply;
        if (bus.cfg_load) begin
            pend_d.hs_start = bus.cfg_h_sync_start;
            pend_d.hs_end   = bus.cfg_h_sync_end;
            pend_d.ha_start = bus.cfg_h_act_start;
            pend_d.ha_end   = bus.cfg_h_act_end;
            pend_d.vs_start = bus.cfg_v_sync_start;
            pend_d.vs_end   = bus.cfg_v_sync_end;
            pend_d.va_start = bus.cfg_v_act_start;
            pend_d.va_end   = bus.cfg_v_act_end;
            pend_vld_d      = 1'b1;
        end

        if (decode) begin
            hs_d  = hs_in ~^ H_SYNC_POLARITY;
            vs_d  = vs_in ~^ V_SYNC_POLARITY;
            hb_d  = !ha_in;
            vb_d  = !va_in;
            de_d  = ha_in && va_in;
            sof_d = bus.start_of_sample && (bus.h_count == eff.ha_start) &&
                    (bus.v_count == eff.va_start);
            eol_d = bus.new_line && va_in && ha_in;
        end else if (state_q == IDLE) begin
            hs_d = !H_SYNC_POLARITY;
            vs_d = !V_SYNC_POLARITY;
            hb_d = 1'b1;
            vb_d = 1'b1;
            de_d = 1'b0;
        end

        // Synchronous clear behaves exactly like reset.
        if (bus.sclr) begin
            state_d    = IDLE;
            pend_d     = '0;
            act_d      = '0;
            pend_vld_d = 1'b0;
            ack_d      = 1'b0;
            hs_d       = !H_SYNC_POLARITY;
            vs_d       = !V_SYNC_POLARITY;
            hb_d       = 1'b1;
            vb_d       = 1'b1;
            de_d       = 1'b0;
            sof_d      = 1'b0;
            eol_d      = 1'b0;
        end
    end

    // State, config and output registers with async reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            pend_q     <= '0;
            act_q      <= '0;
            pend_vld_q <= 1'b0;
            ack_q      <= 1'b0;
            hs_q       <= !H_SYNC_POLARITY;
            vs_q       <= !V_SYNC_POLARITY;
            hb_q       <= 1'b1;
            vb_q       <= 1'b1;
            de_q       <= 1'b0;
            sof_q      <= 1'b0;
            eol_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            act_q      <= act_d;
            pend_vld_q <= pend_vld_d;
            ack_q      <= ack_d;
            hs_q       <= hs_d;
            vs_q       <= vs_d;
            hb_q       <= hb_d;
            vb_q       <= vb_d;
            de_q       <= de_d;
            sof_q      <= sof_d;
            eol_q      <= eol_d;
        end
    end

    assign bus.cfg_ack = ack_q;
    assign bus.running = (state_q == RUN);
    assign bus.h_sync  = hs_q;
    assign bus.v_sync  = vs_q;
    assign bus.h_blank = hb_q;
    assign bus.v_blank = vb_q;
    assign bus.de      = de_q;
    assign bus.sof     = sof_q;
    assign bus.eol     = eol_q;
endmodule

// File: tb/tb_cvo_sync_decoder.sv
// Bench for cvo_sync_decoder: two DUTs (sync polarity 1 and 0) share stimulus;
// a reference model queues expected outputs each cycle, plus a constant table
// and directed multi-cycle sequences.
module tb_cvo_sync_decoder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cvo_sync_decoder_if ifa();
    cvo_sync_decoder_if ifb();

    cvo_sync_decoder #(.H_SYNC_POLARITY(1'b1), .V_SYNC_POLARITY(1'b1)) dut_a (
        .clk(clk), .rst(rst), .bus(ifa.slave));
    cvo_sync_decoder #(.H_SYNC_POLARITY(1'b0), .V_SYNC_POLARITY(1'b0)) dut_b (
        .clk(clk), .rst(rst), .bus(ifb.slave));

    // Output vector order: {ack, running, h_sync, v_sync, h_blank, v_blank, de, sof, eol}
    localparam bit [8:0] RESET_OUT = 9'b0_0_0_0_1_1_0_0_0;
    localparam bit [8:0] SYNC_MASK = 9'b0_0_1_1_0_0_0_0_0;

    typedef struct {
        int       h;
        int       v;
        bit       sos;
        bit       nl;
        bit       en;
        bit [8:0] exp;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;
    bit [8:0] exp_q[$];

    int c[8];
    int m_pend[8];
    int m_act[8];
    bit m_pvld, m_run;
    bit [8:0] m_out;

    function automatic bit [8:0] got_a();
        return {ifa.cfg_ack, ifa.running, ifa.h_sync, ifa.v_sync, ifa.h_blank,
                ifa.v_blank, ifa.de, ifa.sof, ifa.eol};
    endfunction

    function automatic bit [8:0] got_b();
        return {ifb.cfg_ack, ifb.running, ifb.h_sync, ifb.v_sync, ifb.h_blank,
                ifb.v_blank, ifb.de, ifb.sof, ifb.eol};
    endfunction

    function automatic bit inwin(input int s, input int e, input int x);
        if (s < e) return (x >= s) && (x < e);
        if (s > e) return (x >= s) || (x < e);
        return 1'b0;
    endfunction

    task automatic check(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pvld = 1'b0;
        m_run  = 1'b0;
        m_out  = RESET_OUT;
        for (int i = 0; i < 8; i++) begin
            m_pend[i] = 0;
            m_act[i]  = 0;
        end
    endtask

    task automatic set_cfg(input int hs, input int he, input int has, input int hae,
                           input int vs, input int ve, input int vas, input int vae);
        c = '{hs, he, has, hae, vs, ve, vas, vae};
        ifa.cfg_h_sync_start = hs[13:0];  ifb.cfg_h_sync_start = hs[13:0];
        ifa.cfg_h_sync_end   = he[13:0];  ifb.cfg_h_sync_end   = he[13:0];
        ifa.cfg_h_act_start  = has[13:0]; ifb.cfg_h_act_start  = has[13:0];
        ifa.cfg_h_act_end    = hae[13:0]; ifb.cfg_h_act_end    = hae[13:0];
        ifa.cfg_v_sync_start = vs[12:0];  ifb.cfg_v_sync_start = vs[12:0];
        ifa.cfg_v_sync_end   = ve[12:0];  ifb.cfg_v_sync_end   = ve[12:0];
        ifa.cfg_v_act_start  = vas[12:0]; ifb.cfg_v_act_start  = vas[12:0];
        ifa.cfg_v_act_end    = vae[12:0]; ifb.cfg_v_act_end    = vae[12:0];
    endtask

    // One clock: drive inputs, push model expectation, clock, pop and compare.
    task automatic drive(input int h, input int v, input bit sos, input bit nl,
                         input bit en, input bit ld, input bit sc);
        bit fs, ap, hin, vin, ain, vain;
        bit [8:0] e;
        ifa.h_count = h[13:0];  ifb.h_count = h[13:0];
        ifa.v_count = v[12:0];  ifb.v_count = v[12:0];
        ifa.start_of_sample = sos; ifb.start_of_sample = sos;
        ifa.new_line = nl; ifb.new_line = nl;
        ifa.enable = en;   ifb.enable = en;
        ifa.cfg_load = ld; ifb.cfg_load = ld;
        ifa.sclr = sc;     ifb.sclr = sc;
        if (sc) begin
            model_reset();
        end else begin
            fs = en && sos && (h == 0) && (v == 0);
            ap = fs && m_pvld;
            if (ap) m_act = m_pend;
            e = m_out;
            e[1] = 1'b0;
            e[0] = 1'b0;
            if ((m_run || ap) && en) begin
                hin  = inwin(m_act[0], m_act[1], h);
                ain  = inwin(m_act[2], m_act[3], h);
                vin  = inwin(m_act[4], m_act[5], v);
                vain = inwin(m_act[6], m_act[7], v);
                e[6] = hin;
                e[5] = vin;
                e[4] = !ain;
                e[3] = !vain;
                e[2] = ain && vain;
                e[1] = sos && (h == m_act[2]) && (v == m_act[6]);
                e[0] = nl && vain && ain;
            end else if (!(m_run || ap)) begin
                e = RESET_OUT;
            end
            m_run = m_run || ap;
            e[8]  = ap;
            e[7]  = m_run;
            m_pvld = ld || (m_pvld && !ap);
            if (ld) m_pend = c;
            m_out = e;
        end
        exp_q.push_back(m_out);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 1, 0);
        end else begin
            e = exp_q.pop_front();
            check("model_pol1", int'(got_a()), int'(e));
            check("model_pol0", int'(got_b()), int'(e ^ SYNC_MASK));
        end
    endtask

    task automatic idle_inputs();
        ifa.sclr = 0; ifb.sclr = 0;
        ifa.enable = 0; ifb.enable = 0;
        ifa.start_of_sample = 0; ifb.start_of_sample = 0;
        ifa.new_line = 0; ifb.new_line = 0;
        ifa.h_count = '0; ifb.h_count = '0;
        ifa.v_count = '0; ifb.v_count = '0;
        ifa.cfg_load = 0; ifb.cfg_load = 0;
    endtask

    initial begin
        vec_t tbl[14];
        int de_cnt, hs_cnt, vs_cnt, run_cnt, ack_cnt;

        // Wrapping h_sync 2190..9, 1080p active window, v sync 0..4.
        tbl[0]  = '{2189, 50, 1'b1, 1'b0, 1'b1, 9'b0_1_0_0_1_0_0_0_0};
        tbl[1]  = '{2190, 50, 1'b1, 1'b0, 1'b1, 9'b0_1_1_0_1_0_0_0_0};
        tbl[2]  = '{2199, 50, 1'b1, 1'b1, 1'b1, 9'b0_1_1_0_1_0_0_0_0};
        tbl[3]  = '{0,    50, 1'b1, 1'b0, 1'b1, 9'b0_1_1_0_1_0_0_0_0};
        tbl[4]  = '{9,    50, 1'b1, 1'b0, 1'b1, 9'b0_1_1_0_1_0_0_0_0};
        tbl[5]  = '{10,   50, 1'b1, 1'b0, 1'b1, 9'b0_1_0_0_1_0_0_0_0};
        tbl[6]  = '{191,  50, 1'b1, 1'b0, 1'b1, 9'b0_1_0_0_1_0_0_0_0};
        tbl[7]  = '{192,  50, 1'b1, 1'b0, 1'b1, 9'b0_1_0_0_0_0_1_0_0};
        tbl[8]  = '{192,  41, 1'b1, 1'b0, 1'b1, 9'b0_1_0_0_0_0_1_1_0};
        tbl[9]  = '{192,  41, 1'b0, 1'b0, 1'b1, 9'b0_1_0_0_0_0_1_0_0};
        tbl[10] = '{2111, 1120, 1'b1, 1'b1, 1'b1, 9'b0_1_0_0_0_0_1_0_1};
        tbl[11] = '{2112, 1121, 1'b1, 1'b0, 1'b1, 9'b0_1_0_0_1_1_0_0_0};
        tbl[12] = '{100,  3,  1'b1, 1'b0, 1'b1, 9'b0_1_0_1_1_1_0_0_0};
        tbl[13] = '{500,  40, 1'b1, 1'b1, 1'b0, 9'b0_1_0_1_1_1_0_0_0};

        idle_inputs();
        set_cfg(0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("reset_pol1", int'(got_a()), int'(RESET_OUT));
        check("reset_pol0", int'(got_b()), int'(RESET_OUT ^ SYNC_MASK));
        rst = 1'b0;

        // No config loaded: a full small frame stays idle.
        de_cnt = 0; run_cnt = 0;
        for (int v = 0; v < 12; v++)
            for (int h = 0; h < 40; h++) begin
                drive(h, v, 1, h == 39, 1, 0, 0);
                de_cnt  += int'(ifa.de);
                run_cnt += int'(ifa.running);
            end
        check("idle_de_count", de_cnt, 0);
        check("idle_running_count", run_cnt, 0);

        // 1080p load mid-frame; applies at the next frame start.
        set_cfg(0, 44, 192, 2112, 0, 5, 41, 1121);
        drive(100, 7, 1, 0, 1, 1, 0);
        for (int h = 101; h < 104; h++) drive(h, 7, 1, 0, 1, 0, 0);
        check("not_running_before_fs", int'(ifa.running), 0);
        drive(0, 0, 1, 0, 1, 0, 0);
        check("ack_after_fs", int'(ifa.cfg_ack), 1);
        check("running_after_fs", int'(ifa.running), 1);
        for (int h = 1; h < 2200; h++) drive(h, 0, 1, h == 2199, 1, 0, 0);
        de_cnt = 0; hs_cnt = 0;
        for (int h = 0; h < 2200; h++) begin
            drive(h, 50, 1, h == 2199, 1, 0, 0);
            de_cnt += int'(ifa.de);
            hs_cnt += int'(ifa.h_sync);
        end
        check("de_per_line", de_cnt, 1920);
        check("hsync_width", hs_cnt, 44);
        de_cnt = 0; vs_cnt = 0;
        for (int v = 0; v < 1125; v++) begin
            drive(500, v, 0, 0, 1, 0, 0);
            de_cnt += int'(ifa.de);
            vs_cnt += int'(ifa.v_sync);
        end
        check("de_lines", de_cnt, 1080);
        check("vsync_lines", vs_cnt, 5);

        // Loads while running: overwrite pending, old timing persists.
        set_cfg(1, 2, 3, 4, 5, 6, 7, 8);
        drive(20, 60, 1, 0, 1, 1, 0);
        check("old_hs_after_load", int'(ifa.h_sync), 1);
        set_cfg(2190, 10, 192, 2112, 0, 5, 41, 1121);
        drive(21, 60, 1, 0, 1, 1, 0);
        for (int h = 22; h <= 30; h++) drive(h, 60, 1, 0, 1, 0, 0);
        check("old_hs_persists", int'(ifa.h_sync), 1);
        ack_cnt = 0;
        drive(0, 0, 1, 0, 1, 0, 0);
        ack_cnt += int'(ifa.cfg_ack);
        for (int h = 1; h < 4; h++) begin
            drive(h, 0, 1, 0, 1, 0, 0);
            ack_cnt += int'(ifa.cfg_ack);
        end
        check("single_ack", ack_cnt, 1);

        // Constant table against the wrapping-sync timing.
        foreach (tbl[i]) begin
            drive(tbl[i].h, tbl[i].v, tbl[i].sos, tbl[i].nl, tbl[i].en, 0, 0);
            check($sformatf("table_%0d", i), int'(got_a()), int'(tbl[i].exp));
        end

        // enable low for 5 cycles mid-line: levels frozen, no pulses.
        drive(300, 100, 1, 0, 1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            drive(301 + i, 100 + i, 1, 1, 0, 0, 0);
            check("hold_de_sof_eol", int'({ifa.de, ifa.sof, ifa.eol, ifa.h_blank}), 4'b1000);
        end

        // Apply and reload in the same frame-start cycle.
        set_cfg(0, 44, 192, 2112, 0, 5, 41, 1121);
        drive(0, 0, 1, 0, 1, 1, 0);
        check("no_ack_without_pending", int'(ifa.cfg_ack), 0);
        set_cfg(2190, 10, 192, 2112, 0, 5, 41, 1121);
        drive(0, 0, 1, 0, 1, 1, 0);
        check("ack_apply_reload", int'(ifa.cfg_ack), 1);
        drive(30, 0, 1, 0, 1, 0, 0);
        check("hs_1080p_active", int'(ifa.h_sync), 1);
        drive(0, 0, 1, 0, 1, 0, 0);
        check("ack_second_apply", int'(ifa.cfg_ack), 1);
        drive(30, 0, 1, 0, 1, 0, 0);
        check("hs_wrap_active", int'(ifa.h_sync), 0);

        // sclr mid-line.
        drive(300, 100, 1, 0, 1, 0, 0);
        drive(301, 100, 1, 0, 1, 0, 1);
        check("sclr_hsync_pol0", int'(ifb.h_sync), 1);
        check("sclr_de", int'(ifb.de), 0);
        check("sclr_running", int'(ifb.running), 0);
        drive(0, 0, 1, 0, 1, 0, 0);
        check("sclr_fs_no_cfg", int'(ifa.running), 0);

        // Async rst mid-frame, then recovery needs load plus frame start.
        set_cfg(0, 44, 192, 2112, 0, 5, 41, 1121);
        drive(10, 10, 1, 0, 1, 1, 0);
        drive(0, 0, 1, 0, 1, 0, 0);
        drive(300, 100, 1, 0, 1, 0, 0);
        check("pre_rst_de", int'(ifa.de), 1);
        rst = 1'b1;
        #2;
        check("async_rst_pol1", int'(got_a()), int'(RESET_OUT));
        check("async_rst_pol0", int'(got_b()), int'(RESET_OUT ^ SYNC_MASK));
        model_reset();
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(0, 0, 1, 0, 1, 0, 0);
        check("rst_fs_no_cfg", int'(ifa.running), 0);
        drive(5, 0, 1, 0, 1, 1, 0);
        drive(0, 0, 1, 0, 1, 0, 0);
        check("rst_recover", int'(ifa.running), 1);
        for (int h = 1; h < 200; h++) drive(h, 41, 1, 0, 1, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
